// File: rtl/posit_mult_arbiter.sv
// Round-robin front end sharing one fixed-latency posit multiplier among NREQ requesters;
// results return in issue order through a response FIFO. Macro POSIT_ARB_PRIO0_EN: requester 0 strict priority.
module posit_mult_arbiter #(
   parameter int NREQ         = 4,
   parameter int MULT_LATENCY = 1,
   parameter int DEPTH        = 4,
   parameter int TAGW         = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid_i,
   output logic [NREQ-1:0]   req_ready_o,
   input  logic [8*NREQ-1:0] req_lhs_i,
   input  logic [8*NREQ-1:0] req_rhs_i,
   output logic [7:0]        mult_lhs_o,
   output logic [7:0]        mult_rhs_o,
   input  logic [20:0]       mult_result_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [TAGW-1:0]   resp_tag_o,
   output logic [20:0]       resp_result_o,
   output logic              busy_o
);

   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;
   localparam int SRN = MULT_LATENCY + 1;
   localparam int EW  = TAGW + 21;
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [TAGW:0] NREQ_C  = (TAGW+1)'(NREQ);

   logic [TAGW-1:0] rr_q, rr_d;
   logic [7:0]      lhs_q, lhs_d, rhs_q, rhs_d;
   logic [SRN-1:0]  sr_vld_q, sr_vld_d;
   logic [TAGW-1:0] sr_tag_q [SRN];
   logic [TAGW-1:0] sr_tag_d [SRN];
   logic [CW-1:0]   inflight_q, inflight_d, count_q, count_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [EW-1:0]   mem_q [DEPTH];
   logic [EW-1:0]   head_q, head_d, wdata_s;
   logic [NREQ-1:0] cand_s;
   logic [TAGW:0]   sum_s;
   logic [TAGW-1:0] gnt_idx_s;
   logic            gnt_vld_s, prio_s, credit_s, issue_s, push_s, pop_s;

   // Grant search from rr with wrap; offsets walk downward so the smallest offset wins.
   always_comb begin
      cand_s    = req_valid_i;
      gnt_vld_s = 1'b0;
      gnt_idx_s = '0;
      sum_s     = '0;
      prio_s    = 1'b0;
`ifdef POSIT_ARB_PRIO0_EN
      cand_s[0] = 1'b0;
`endif
      for (int off = NREQ - 1; off >= 0; off--) begin
         sum_s     = {1'b0, rr_q} + (TAGW+1)'(off);
         sum_s     = (sum_s >= NREQ_C) ? (sum_s - NREQ_C) : sum_s;
         gnt_vld_s = gnt_vld_s | cand_s[sum_s[TAGW-1:0]];
         gnt_idx_s = cand_s[sum_s[TAGW-1:0]] ? sum_s[TAGW-1:0] : gnt_idx_s;
      end
`ifdef POSIT_ARB_PRIO0_EN
      if (req_valid_i[0]) begin
         gnt_vld_s = 1'b1;
         gnt_idx_s = '0;
         prio_s    = 1'b1;
      end else begin
         prio_s    = 1'b0;
      end
`endif
   end

   // Credit check and grant; held low while reset is asserted.
   always_comb begin
      credit_s    = ({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_C;
      issue_s     = rst_n & credit_s & gnt_vld_s;
      req_ready_o = '0;
      if (issue_s) begin
         req_ready_o[gnt_idx_s] = 1'b1;
      end else begin
         req_ready_o = '0;
      end
   end

   // Operand registers, round-robin pointer and tag/valid pipeline next state.
   always_comb begin
      lhs_d = lhs_q;
      rhs_d = rhs_q;
      rr_d  = rr_q;
      if (issue_s) begin
         lhs_d = req_lhs_i[{gnt_idx_s, 3'b000} +: 8];
         rhs_d = req_rhs_i[{gnt_idx_s, 3'b000} +: 8];
      end else begin
         lhs_d = lhs_q;
         rhs_d = rhs_q;
      end
      if (issue_s && !prio_s) begin
         rr_d = (({1'b0, gnt_idx_s} + (TAGW+1)'(1)) == NREQ_C) ? '0 : (gnt_idx_s + TAGW'(1));
      end else begin
         rr_d = rr_q;
      end
      sr_vld_d    = {sr_vld_q[SRN-2:0], issue_s};
      sr_tag_d[0] = gnt_idx_s;
      for (int s = 1; s < SRN; s++) begin
         sr_tag_d[s] = sr_tag_q[s-1];
      end
   end

   assign push_s       = sr_vld_q[SRN-1];
   assign wdata_s      = {sr_tag_q[SRN-1], mult_result_i};
   assign resp_valid_o = (count_q != '0);
   assign pop_s        = resp_valid_o & resp_ready_i;

   // Counters, FIFO pointers and the registered head entry.
   always_comb begin
      case ({issue_s, push_s})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
      // The entry being written this edge bypasses storage when it becomes the head.
      if (push_s && (wr_ptr_q == rd_ptr_d)) begin
         head_d = wdata_s;
      end else if (count_d != '0) begin
         head_d = mem_q[rd_ptr_d];
      end else begin
         head_d = head_q;
      end
   end

   // Control and output state with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q       <= '0;
         lhs_q      <= 8'h00;
         rhs_q      <= 8'h00;
         sr_vld_q   <= '0;
         inflight_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         head_q     <= '0;
         for (int s = 0; s < SRN; s++) begin
            sr_tag_q[s] <= '0;
         end
      end else begin
         rr_q       <= rr_d;
         lhs_q      <= lhs_d;
         rhs_q      <= rhs_d;
         sr_vld_q   <= sr_vld_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         head_q     <= head_d;
         for (int s = 0; s < SRN; s++) begin
            sr_tag_q[s] <= sr_tag_d[s];
         end
      end
   end

   // FIFO storage; only observable through head_q, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= wdata_s;
      end
   end

   assign mult_lhs_o    = lhs_q;
   assign mult_rhs_o    = rhs_q;
   assign resp_tag_o    = head_q[EW-1:21];
   assign resp_result_o = head_q[20:0];
   assign busy_o        = (inflight_q != '0) | (count_q != '0);

endmodule

// File: doc/posit_mult_arbiter.md
# posit_mult_arbiter

Shares one `clocked_mult_8bit` posit multiplier among `NREQ` requesters. Each requester has a valid/ready port. The arbiter grants round-robin, issues one multiplication per cycle into the fixed-latency multiplier, and returns each 21-bit unpacked result with its requester tag through an output FIFO. It sits between the scalar posit front-ends and the shared multiplier instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `MULT_LATENCY`, 1: clock edges from the multiplier sampling its operands to `mult_result` being valid, 1..4.
- `DEPTH`, 4: response FIFO entries; power of two, at least `MULT_LATENCY`+1.
- `TAGW`, 2: tag width, equal to clog2(`NREQ`).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NREQ`  per-requester request valid.
- `req_ready`  out  `NREQ`  per-requester grant; one-hot or zero.
- `req_lhs`  in  8*`NREQ`  left posits; requester i occupies bits [8i+7:8i].
- `req_rhs`  in  8*`NREQ`  right posits, packed the same way.
- `mult_lhs`  out  8  registered left operand to the multiplier.
- `mult_rhs`  out  8  registered right operand to the multiplier.
- `mult_result`  in  21  unpacked multiplier result.
- `resp_valid`  out  1  response FIFO non-empty.
- `resp_ready`  in  1  consumer accepts the head entry.
- `resp_tag`  out  `TAGW`  requester index of the head entry.
- `resp_result`  out  21  result of the head entry.
- `busy`  out  1  any operation in flight or queued.

## Operation
- **Credit check.** `inflight` counts operations issued but not yet written to the FIFO; `count` is FIFO occupancy. Issue is permitted only when `inflight` + `count` < `DEPTH`. When issue is not permitted, all `req_ready` bits are 0.
- **Arbitration.** Round-robin from pointer `rr`. The grant goes to the first i, searching upward from `rr` with wrap-around, that has `req_valid`[i]=1. `req_ready` is combinational from `req_valid`, `rr` and the credit check. It never depends on the requester's own ready.
- **Issue** (handshake at edge k):
  - `mult_lhs`/`mult_rhs` load the granted operands.
  - The granted index enters a `MULT_LATENCY`+1 stage tag/valid shift register.
  - `rr` becomes the granted index + 1, modulo `NREQ`.
  - On cycles with no issue, the operand registers hold their values and a 0 valid bit enters the shift register.
- **Capture.** When the shift-register tail valid is 1 at edge k+`MULT_LATENCY`+1, {tail tag, `mult_result`} is written to the FIFO. The credit check guarantees the FIFO is never full at a write.
- **FIFO.** Circular buffer; read and write pointers wrap at `DEPTH`. A pop happens on `resp_valid`&`resp_ready`. A push and a pop on the same edge leave `count` unchanged, and this is legal with the FIFO full or empty. Ordering is strict issue order.
- **Counters.** `inflight` increments on issue and decrements on capture; both on one edge leave it unchanged.
- **Busy.** `busy` = (`inflight` != 0) | (`count` != 0).
- **Reset** (asynchronous, any time, including mid-operation):
  - `mult_lhs`/`mult_rhs` = 8'h00.
  - Shift register cleared; in-flight operations are discarded.
  - FIFO emptied; `count` = 0, `inflight` = 0, `rr` = 0.
  - Outputs: `req_ready` = 0, `resp_valid` = 0, `resp_tag` = 0, `resp_result` = 0, `busy` = 0.
- **Requester rule.** A requester must hold `req_valid` and its operands stable until granted. The arbiter does not check this.

## Timing
- Throughput: one issue per cycle while credits and requests are available.
- Minimum latency: handshake at edge k gives `resp_valid` high in the cycle after edge k+`MULT_LATENCY`+1. With default parameters that is 3 cycles after the request cycle.
- `resp_tag`/`resp_result` are registered FIFO head outputs. They are stable while `resp_valid`=1 and `resp_ready`=0.
- First edge after `rst_n` deasserts: a grant is possible if `req_valid` is set.
- With `resp_ready` held at 0, exactly `DEPTH` operations are accepted, then `req_ready` stays 0. After the first pop, issue resumes on the next edge.

## Configuration
- `POSIT_ARB_PRIO0_EN` defined: requester 0 has strict priority. If `req_valid`[0]=1 and the credit check passes, requester 0 is granted and `rr` is unchanged. Requesters 1..`NREQ`-1 round-robin among themselves when `req_valid`[0]=0.
- Not defined: pure round-robin across all `NREQ` requesters. No priority logic is synthesized.

## Test plan
- **Single request.** Reset, then requester 2 issues lhs=8'h66, rhs=8'hdb with `resp_ready`=1 -> one response with tag=2, result=21'h5ed20, `resp_valid` high exactly `MULT_LATENCY`+2 cycles after the request cycle.
- **Round-robin order.** All four requesters valid in the same cycle: 0:(8'h8f,8'h3a), 1:(8'hb2,8'he2), 2:(8'h66,8'hdb), 3:(8'h20,8'h60) -> grants in order 0,1,2,3 on consecutive edges. Responses in the same order; tag 0 gives 21'h63f60 and tag 1 gives 21'h1cb20.
- **Backpressure.** `resp_ready`=0 while 6 requests are pending -> exactly `DEPTH`=4 accepted, then `req_ready`=0 and `busy`=1. Raise `resp_ready` -> the remaining 2 are issued, with no loss or reorder.
- **Simultaneous push/pop.** Full FIFO, then continuous `resp_ready`=1 with continuous requests -> one response and one issue per cycle in steady state; `count` never exceeds `DEPTH`.
- **Reset mid-operation.** Assert `rst_n`=0 with 2 in flight and 2 queued -> all outputs go to their reset values immediately. After release, stale results never appear and the next request returns the correct result.
- **Priority macro.** With `POSIT_ARB_PRIO0_EN` defined, requesters 0 and 1 valid continuously -> requester 0 is granted every cycle. Requester 0 drops -> requester 1 is granted.
